// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared definitions for the NPU datapath stages.
//   state_t : frame-control state encoding (IDLE / RUN / DRAIN)
//   relu32  : clamp a signed value at zero
//   max32   : signed maximum of two values
// The helpers work on 32-bit signed values. Callers sign-extend narrower
// operands into them and truncate the result back to their own width.
// -----------------------------------------------------------------------------
package npu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic signed [31:0] relu32(input logic signed [31:0] x);
    return (x < 0) ? 32'sd0 : x;
  endfunction

  function automatic logic signed [31:0] max32(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// -----------------------------------------------------------------------------
// pool_row_buffer
// Holds the horizontal pair maxima of an even input row. The following odd
// row reads them back to complete each 2x2 window.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write slot (pooled column)
//   i_wdata : pair maximum to store
//   i_raddr : read slot (pooled column), combinational read
//   o_rdata : stored pair maximum
// There is no reset. Every slot is written in an even row before the odd row
// reads it. The depth is rounded up to a power of two so that any address
// value indexes a real slot.
// -----------------------------------------------------------------------------
module pool_row_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 2
) (
  input  logic                         i_clk,
  input  logic                         i_we,
  input  logic [ADDR_W-1:0]            i_waddr,
  input  logic signed [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]            i_raddr,
  output logic signed [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/relu_maxpool2x2.sv
// -----------------------------------------------------------------------------
// relu_maxpool2x2
// Takes the raster-order stream from the 3x3 conv engine. It applies ReLU,
// does 2x2 / stride-2 max pooling, and writes each pooled pixel out together
// with its feature-map SRAM address.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : begin a frame (sampled in IDLE only)
//   i_valid/i_data, o_ready          : conv input stream (valid/ready)
//   o_valid/o_data/o_wr_addr, i_ready: pooled output stream (valid/ready)
//   o_busy       : frame in progress (RUN or DRAIN)
//   o_done       : one-cycle pulse when the frame has fully drained
// If OUT_W or OUT_H is odd, the trailing column or row is accepted and then
// discarded.
// -----------------------------------------------------------------------------
module relu_maxpool2x2
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int OUT_W           = 8,
  parameter int OUT_H           = 8,
  parameter int SRAM_ADDR_WIDTH = 4,
  parameter int RELU_EN         = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_start,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_ready,
  output logic                         o_valid,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [SRAM_ADDR_WIDTH-1:0]   o_wr_addr,
  input  logic                         i_ready,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int ROW_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int HALF_W = OUT_W / 2;
  localparam int RB_AW  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);
  localparam bit TRAIL_ROW = (OUT_H % 2) != 0;

  function automatic logic signed [DATA_WIDTH-1:0] relu_f(
    input logic signed [DATA_WIDTH-1:0] x);
    return DATA_WIDTH'(relu32(32'(x)));
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] max_f(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b);
    return DATA_WIDTH'(max32(32'(a), 32'(b)));
  endfunction

  state_t                       state;
  logic [COL_W-1:0]             col;
  logic [ROW_W-1:0]             row;
  logic signed [DATA_WIDTH-1:0] pair_p0;

  logic                         accept;
  logic                         last_in;
  logic                         row_keep;
  logic                         rb_we;
  logic                         pool_load;
  logic signed [DATA_WIDTH-1:0] v;
  logic signed [DATA_WIDTH-1:0] pm;
  logic signed [DATA_WIDTH-1:0] rb_rdata;
  logic signed [DATA_WIDTH-1:0] pool_val;
  logic [RB_AW-1:0]             rb_addr;
  logic [SRAM_ADDR_WIDTH-1:0]   pool_addr;

  // Input side: handshake, activation, horizontal pair maximum
  assign o_ready = (state == ST_RUN) && (!o_valid || i_ready);
  assign accept  = i_valid && o_ready;
  assign last_in = accept && (col == COL_LAST) && (row == ROW_LAST);
  assign v       = (RELU_EN != 0) ? relu_f(i_data) : i_data;
  assign pm      = max_f(pair_p0, v);

  // The buffer slot index is truncated. An odd trailing column has an even
  // index and never reads or writes the buffer, so truncation cannot alias a
  // live slot.
  assign rb_addr   = RB_AW'(col >> 1);
  assign row_keep  = !(TRAIL_ROW && (row == ROW_LAST));
  assign rb_we     = accept && col[0] && !row[0] && row_keep;
  assign pool_load = accept && col[0] && row[0];
  assign pool_val  = max_f(pm, rb_rdata);
  assign pool_addr = SRAM_ADDR_WIDTH'(int'(row >> 1) * HALF_W + int'(col >> 1));
  assign o_busy    = (state != ST_IDLE);

  pool_row_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (RB_AW)
  ) u_rowbuf (
    .i_clk   (i_clk),
    .i_we    (rb_we),
    .i_waddr (rb_addr),
    .i_wdata (pm),
    .i_raddr (rb_addr),
    .o_rdata (rb_rdata)
  );

  // Frame control and raster counters
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      col    <= '0;
      row    <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state <= ST_RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_in) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The last pooled pixel is either absent or being taken this cycle.
          if (!o_valid || i_ready) begin
            state  <= ST_IDLE;
            o_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pair register: holds the even-column pixel until its odd partner arrives
  always_ff @(posedge i_clk) begin
    if (accept && !col[0]) begin
      pair_p0 <= v;
    end
  end

  // Output register. o_ready blocks new input while a stalled pixel is held,
  // so a load only happens when the register is empty or being taken.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_wr_addr <= '0;
    end else if (pool_load) begin
      o_valid   <= 1'b1;
      o_data    <= pool_val;
      o_wr_addr <= pool_addr;
    end else if (o_valid && i_ready) begin
      o_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// -----------------------------------------------------------------------------
// tb_relu_maxpool2x2
// Four instances cover the parameter sets under test:
//   0: 8x8 ReLU on, 1: 8x8 ReLU off, 2: 4x2 ReLU on, 3: 5x3 ReLU on.
// The expected pooled pixels of each frame are computed directly from the
// input image (2x2 window maxima). One compare process checks every output
// handshake, hold-while-stalled and o_ready/o_done rules.
// -----------------------------------------------------------------------------
module tb_relu_maxpool2x2;

  localparam int NI = 4;
  localparam int W_OF    [NI] = '{8, 8, 4, 5};
  localparam int H_OF    [NI] = '{8, 8, 2, 3};
  localparam int RELU_OF [NI] = '{1, 0, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st  [NI];
  logic       vl  [NI];
  logic       rdy [NI];
  logic [7:0] dat [NI];
  logic       or_ [NI];
  logic       ov  [NI];
  logic       ob  [NI];
  logic       dn  [NI];
  logic [7:0] od  [NI];
  logic [3:0] oa  [NI];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  relu_maxpool2x2 #(.DATA_WIDTH(8), .OUT_W(8), .OUT_H(8), .SRAM_ADDR_WIDTH(4), .RELU_EN(1)) u_d0 (
    .i_clk(clk), .i_rst(rst), .i_start(st[0]), .i_valid(vl[0]), .i_data(dat[0]), .o_ready(or_[0]),
    .o_valid(ov[0]), .o_data(od[0]), .o_wr_addr(oa[0]), .i_ready(rdy[0]), .o_busy(ob[0]), .o_done(dn[0]));
  relu_maxpool2x2 #(.DATA_WIDTH(8), .OUT_W(8), .OUT_H(8), .SRAM_ADDR_WIDTH(4), .RELU_EN(0)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_start(st[1]), .i_valid(vl[1]), .i_data(dat[1]), .o_ready(or_[1]),
    .o_valid(ov[1]), .o_data(od[1]), .o_wr_addr(oa[1]), .i_ready(rdy[1]), .o_busy(ob[1]), .o_done(dn[1]));
  relu_maxpool2x2 #(.DATA_WIDTH(8), .OUT_W(4), .OUT_H(2), .SRAM_ADDR_WIDTH(4), .RELU_EN(1)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_start(st[2]), .i_valid(vl[2]), .i_data(dat[2]), .o_ready(or_[2]),
    .o_valid(ov[2]), .o_data(od[2]), .o_wr_addr(oa[2]), .i_ready(rdy[2]), .o_busy(ob[2]), .o_done(dn[2]));
  relu_maxpool2x2 #(.DATA_WIDTH(8), .OUT_W(5), .OUT_H(3), .SRAM_ADDR_WIDTH(4), .RELU_EN(1)) u_d3 (
    .i_clk(clk), .i_rst(rst), .i_start(st[3]), .i_valid(vl[3]), .i_data(dat[3]), .o_ready(or_[3]),
    .o_valid(ov[3]), .o_data(od[3]), .o_wr_addr(oa[3]), .i_ready(rdy[3]), .o_busy(ob[3]), .o_done(dn[3]));

  // Model state
  int pix [64];
  int exp_d [NI][64];
  int exp_a [NI][64];
  int exp_n [NI];
  int exp_rd [NI];
  int hs_cnt [NI];
  int done_cnt [NI];
  int last_hs [NI];
  int done_cyc [NI];
  int rmode [NI];
  int stall_left [NI];

  logic       stall_prev [NI];
  logic [7:0] pd [NI];
  logic [3:0] pa [NI];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic report_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Expected output list for the frame currently in pix[]
  task automatic build_model(input int k);
    int w, h, m, v, n;
    w = W_OF[k];
    h = H_OF[k];
    n = 0;
    for (int pr = 0; pr < h / 2; pr++) begin
      for (int pc = 0; pc < w / 2; pc++) begin
        m = -1000;
        for (int dy = 0; dy < 2; dy++) begin
          for (int dx = 0; dx < 2; dx++) begin
            v = pix[(2 * pr + dy) * w + 2 * pc + dx];
            if (RELU_OF[k] != 0 && v < 0) v = 0;
            if (v > m) m = v;
          end
        end
        exp_d[k][n] = m & 255;
        exp_a[k][n] = pr * (w / 2) + pc;
        n++;
      end
    end
    exp_n[k]  = n;
    exp_rd[k] = 0;
    hs_cnt[k] = 0;
  endtask

  // Compare process: values sampled here are those seen by the next rising edge
  always begin
    @(negedge clk);
    #3;
    if (rst !== 1'b1) begin
      for (int k = 0; k < NI; k++) begin
        if (stall_prev[k]) begin
          check($sformatf("hold_valid_%0d", k), 32'(ov[k]), 32'd1);
          check($sformatf("hold_data_%0d", k), 32'(od[k]), 32'(pd[k]));
          check($sformatf("hold_addr_%0d", k), 32'(oa[k]), 32'(pa[k]));
        end
        if (ov[k] && !rdy[k]) check($sformatf("ready_low_in_stall_%0d", k), 32'(or_[k]), 32'd0);
        if (dn[k]) begin
          done_cnt[k]++;
          done_cyc[k] = cyc;
          check($sformatf("ready_low_at_done_%0d", k), 32'(or_[k]), 32'd0);
        end
        if (ov[k] && rdy[k]) begin
          hs_cnt[k]++;
          last_hs[k] = cyc;
          if (exp_rd[k] < exp_n[k]) begin
            check($sformatf("out_data_%0d_%0d", k, exp_rd[k]), 32'(od[k]), 32'(exp_d[k][exp_rd[k]]));
            check($sformatf("out_addr_%0d_%0d", k, exp_rd[k]), 32'(oa[k]), 32'(exp_a[k][exp_rd[k]]));
            exp_rd[k]++;
          end else begin
            report_fail($sformatf("extra_output_%0d data %0d addr %0d", k, od[k], oa[k]));
          end
        end
        stall_prev[k] = ov[k] && !rdy[k];
        pd[k] = od[k];
        pa[k] = oa[k];
      end
    end else begin
      for (int k = 0; k < NI; k++) stall_prev[k] = 1'b0;
    end
  end

  task automatic drive_ready(input int k);
    case (rmode[k])
      0: rdy[k] = 1'b1;
      1: begin
        if (stall_left[k] > 0 && ov[k]) begin
          rdy[k] = 1'b0;
          stall_left[k]--;
        end else begin
          rdy[k] = 1'b1;
        end
      end
      default: rdy[k] = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic start_frame(input int k);
    @(negedge clk);
    st[k] = 1'b1;
    drive_ready(k);
    @(negedge clk);
    st[k] = 1'b0;
  endtask

  task automatic feed_pixel(input int k, input int i);
    logic got;
    got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(negedge clk);
      vl[k]  = 1'b1;
      dat[k] = 8'(pix[i]);
      drive_ready(k);
      #1;
      got = or_[k];
    end
    if (!got) report_fail($sformatf("accept_timeout_%0d pixel %0d", k, i));
  endtask

  task automatic finish_frame(input int k);
    int   d0;
    logic seen;
    d0   = done_cnt[k];
    seen = 1'b0;
    for (int t = 0; t < 400 && !seen; t++) begin
      @(negedge clk);
      vl[k] = 1'b0;
      drive_ready(k);
      #1;
      seen = dn[k];
    end
    if (!seen) report_fail($sformatf("done_timeout_%0d", k));
    check($sformatf("all_outputs_seen_%0d", k), 32'(exp_rd[k]), 32'(exp_n[k]));
    @(negedge clk);
    rdy[k] = 1'b1;
    #4;
    check($sformatf("done_one_cycle_%0d", k), 32'(dn[k]), 32'd0);
    check($sformatf("idle_after_done_%0d", k), 32'(ob[k]), 32'd0);
    check($sformatf("done_count_%0d", k), 32'(done_cnt[k]), 32'(d0 + 1));
  endtask

  task automatic run_frame(input int k, input int mode);
    rmode[k]      = mode;
    stall_left[k] = 10;
    build_model(k);
    start_frame(k);
    for (int i = 0; i < W_OF[k] * H_OF[k]; i++) feed_pixel(k, i);
    finish_frame(k);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int d0;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      st[k] = 1'b0; vl[k] = 1'b0; rdy[k] = 1'b1; dat[k] = 8'd0;
      stall_prev[k] = 1'b0; rmode[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_valid_%0d", k), 32'(ov[k]), 32'd0);
      check($sformatf("rst_data_%0d", k), 32'(od[k]), 32'd0);
      check($sformatf("rst_addr_%0d", k), 32'(oa[k]), 32'd0);
      check($sformatf("rst_busy_%0d", k), 32'(ob[k]), 32'd0);
      check($sformatf("rst_done_%0d", k), 32'(dn[k]), 32'd0);
      check($sformatf("rst_ready_%0d", k), 32'(or_[k]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // 4x2 frame, hand-computed: 5 at addr 0, 7 at addr 1
    pix[0] = 1; pix[1] = -3; pix[2] = 7;  pix[3] = 2;
    pix[4] = 4; pix[5] = 5;  pix[6] = -8; pix[7] = 0;
    build_model(2);
    check("model_4x2_count", 32'(exp_n[2]), 32'd2);
    check("model_4x2_d0", 32'(exp_d[2][0]), 32'd5);
    check("model_4x2_d1", 32'(exp_d[2][1]), 32'd7);
    check("model_4x2_a1", 32'(exp_a[2][1]), 32'd1);
    run_frame(2, 0);
    check("outs_4x2", 32'(hs_cnt[2]), 32'd2);
    check("done_latency_4x2", 32'(done_cyc[2] - last_hs[2]), 32'd1);

    // 8x8 ramp, continuous flow
    for (int i = 0; i < 64; i++) pix[i] = i;
    build_model(0);
    check("model_ramp_d0", 32'(exp_d[0][0]), 32'd9);
    check("model_ramp_d1", 32'(exp_d[0][1]), 32'd11);
    check("model_ramp_d4", 32'(exp_d[0][4]), 32'd25);
    check("model_ramp_d15", 32'(exp_d[0][15]), 32'd63);
    run_frame(0, 0);
    check("outs_ramp", 32'(hs_cnt[0]), 32'd16);

    // Reset after 5 accepts abandons the frame without o_done
    rmode[0] = 0;
    build_model(0);
    start_frame(0);
    for (int i = 0; i < 5; i++) feed_pixel(0, i);
    @(negedge clk);
    vl[0] = 1'b0;
    rst   = 1'b1;
    d0    = done_cnt[0];
    @(posedge clk);
    #1;
    check("midrst_valid", 32'(ov[0]), 32'd0);
    check("midrst_busy", 32'(ob[0]), 32'd0);
    check("midrst_ready", 32'(or_[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_n[0]  = 0;
    exp_rd[0] = 0;
    repeat (5) @(negedge clk);
    #4;
    check("midrst_no_done", 32'(done_cnt[0]), 32'(d0));
    check("midrst_idle", 32'(ob[0]), 32'd0);

    // Full ramp frame after the reset, with a 10-cycle consumer stall
    run_frame(0, 1);
    check("outs_stall", 32'(hs_cnt[0]), 32'd16);

    // All -5: ReLU gives 0, pass-through gives 0xFB
    for (int i = 0; i < 64; i++) pix[i] = -5;
    build_model(0);
    build_model(1);
    check("model_relu_neg", 32'(exp_d[0][7]), 32'd0);
    check("model_pass_neg", 32'(exp_d[1][7]), 32'd251);
    run_frame(0, 0);
    run_frame(1, 0);
    check("outs_relu_neg", 32'(hs_cnt[0]), 32'd16);
    check("outs_pass_neg", 32'(hs_cnt[1]), 32'd16);

    // 5x3: trailing column and row are dropped
    for (int i = 0; i < 15; i++) pix[i] = i;
    build_model(3);
    check("model_5x3_count", 32'(exp_n[3]), 32'd2);
    check("model_5x3_d0", 32'(exp_d[3][0]), 32'd6);
    check("model_5x3_d1", 32'(exp_d[3][1]), 32'd8);
    run_frame(3, 0);
    check("outs_5x3", 32'(hs_cnt[3]), 32'd2);

    // Signed random data with random consumer back-pressure
    for (int i = 0; i < 64; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
    run_frame(0, 2);
    run_frame(1, 2);
    check("outs_rand_relu", 32'(hs_cnt[0]), 32'd16);
    check("outs_rand_pass", 32'(hs_cnt[1]), 32'd16);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
